// File: rtl/coco_pkg.sv
// coco_pkg: shared requester/state types and default bus widths for the
// dragoncoco system RAM arbiter.
package coco_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_VID,
    REQ_CPU,
    REQ_LD
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DATA
  } arb_state_t;

endpackage

// File: rtl/coco_ram_arb_pick.sv
// coco_ram_arb_pick: combinational winner selection for one RAM slot.
// Video normally wins; a starved CPU jumps the queue.
module coco_ram_arb_pick
  import coco_pkg::*;
(
  input  logic vid_pend,
  input  logic cpu_pend,
  input  logic ld_pend,
  input  logic starve_hit,
  output req_t winner
);

  always_comb begin
    winner = REQ_NONE;
    if (starve_hit && cpu_pend) begin
      winner = REQ_CPU;
    end else if (vid_pend) begin
      winner = REQ_VID;
    end else if (cpu_pend) begin
      winner = REQ_CPU;
    end else if (ld_pend) begin
      winner = REQ_LD;
    end
  end

endmodule

// File: rtl/coco_ram_arbiter.sv
// coco_ram_arbiter: time-slot arbiter sharing one single-port 1-cycle-latency
// RAM between the VDG fetcher, the 6809 CPU and the ioctl loader.
module coco_ram_arbiter
  import coco_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_busy,
  output logic              ld_overrun,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t        state;
  req_t              owner;
  req_t              winner;
  logic [3:0]        starve_cnt;
  logic              starve_hit;
  logic [ADDR_W-1:0] ld_hold_addr;
  logic [DATA_W-1:0] ld_hold_data;

  assign starve_hit = (starve_cnt == LIMIT) && cpu_req;

  coco_ram_arb_pick u_pick (
    .vid_pend   (vid_req),
    .cpu_pend   (cpu_req),
    .ld_pend    (ld_busy),
    .starve_hit (starve_hit),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= REQ_NONE;
      starve_cnt   <= '0;
      ld_hold_addr <= '0;
      ld_hold_data <= '0;
      vid_ack      <= 1'b0;
      vid_rvalid   <= 1'b0;
      vid_rdata    <= '0;
      cpu_ack      <= 1'b0;
      cpu_rvalid   <= 1'b0;
      cpu_rdata    <= '0;
      ld_busy      <= 1'b0;
      ld_overrun   <= 1'b0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
    end else begin
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;

      // A strobe landing while the holder is full (including its grant cycle) is lost.
      if (ld_wr) begin
        if (ld_busy) begin
          ld_overrun <= 1'b1;
        end else begin
          ld_busy      <= 1'b1;
          ld_hold_addr <= ld_addr;
          ld_hold_data <= ld_data;
        end
      end

      case (state)
        IDLE: begin
          if (!cpu_req || winner == REQ_CPU) begin
            starve_cnt <= '0;
          end else if (winner == REQ_VID && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
          owner <= winner;
          case (winner)
            REQ_VID: begin
              ram_en   <= 1'b1;
              ram_we   <= 1'b0;
              ram_addr <= vid_addr;
              vid_ack  <= 1'b1;
              state    <= ACCESS;
            end
            REQ_CPU: begin
              ram_en   <= 1'b1;
              ram_we   <= cpu_we;
              ram_addr <= cpu_addr;
              ram_din  <= cpu_wdata;
              cpu_ack  <= 1'b1;
              state    <= ACCESS;
            end
            REQ_LD: begin
              ram_en   <= 1'b1;
              ram_we   <= 1'b1;
              ram_addr <= ld_hold_addr;
              ram_din  <= ld_hold_data;
              ld_busy  <= 1'b0;
              state    <= ACCESS;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
        ACCESS: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          state  <= ram_we ? IDLE : DATA;
        end
        DATA: begin
          if (owner == REQ_VID) begin
            vid_rdata  <= ram_dout;
            vid_rvalid <= 1'b1;
          end else if (owner == REQ_CPU) begin
            cpu_rdata  <= ram_dout;
            cpu_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coco_ram_arbiter.sv
// tb_coco_ram_arbiter: directed tests plus a per-cycle transaction-level model
// of the shared RAM and its three requesters.
module tb_coco_ram_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic        vid_rvalid;
  logic [7:0]  vid_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        ld_wr;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_busy;
  logic        ld_overrun;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  int errors = 0;
  int checks = 0;

  coco_ram_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (8),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ld_wr      (ld_wr),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_busy    (ld_busy),
    .ld_overrun (ld_overrun),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'h1234) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RAM primitive: 64K x 8, read data appears one cycle after ram_en.
  logic [7:0] ram_arr [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram_arr[i] = init_val(16'(i));
    ram_dout <= '0;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) ram_arr[ram_addr] = ram_din;
        else        ram_dout <= ram_arr[ram_addr];
      end
    end
  end

  // Reference model: expected memory contents, loader holder, read returns two cycles after ack.
  logic [7:0]  ref_mem [0:65535];
  bit          m_busy, m_ovr, ld_fell, rst_last;
  logic [15:0] m_ld_addr;
  logic [7:0]  m_ld_data;
  bit          vp0, vp1, cp0, cp1, vnew, cnew;
  logic [7:0]  vd0, vd1, cd0, cd1, vnd, cnd, last_v, last_c;
  int          cpu_wait;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    m_busy = 0; m_ovr = 0; rst_last = 0; cpu_wait = 0;
    vp0 = 0; vp1 = 0; cp0 = 0; cp1 = 0;
    vd0 = '0; vd1 = '0; cd0 = '0; cd1 = '0; last_v = '0; last_c = '0;
    m_ld_addr = '0; m_ld_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_last) begin
        checkOutput("reset_outputs",
                    64'({vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
                         ld_busy, ld_overrun, ram_en, ram_we, ram_addr, ram_din}), 64'd0);
        m_busy = 0; m_ovr = 0; cpu_wait = 0;
        vp0 = 0; vp1 = 0; cp0 = 0; cp1 = 0; last_v = '0; last_c = '0;
      end else begin
        ld_fell = m_busy && !ld_busy;
        vnew = 0; cnew = 0; vnd = '0; cnd = '0;
        checkOutput("ram_en", ram_en, vid_ack | cpu_ack | ld_fell);
        checkOutput("multi_grant", $countones({vid_ack, cpu_ack, ld_fell}) > 1, 0);
        if (vid_ack) begin
          checkOutput("vid_ack_without_req", vid_req, 1);
          checkOutput("vid_ram_op", {ram_we, ram_addr}, {1'b0, vid_addr});
          vnew = 1; vnd = ref_mem[vid_addr];
        end
        if (cpu_ack) begin
          checkOutput("cpu_ack_without_req", cpu_req, 1);
          checkOutput("cpu_ram_op", {ram_we, ram_addr}, {cpu_we, cpu_addr});
          checkOutput("cpu_wait_bound", cpu_wait <= STARVE_LIMIT * 3 + 3, 1);
          if (cpu_we) begin
            checkOutput("cpu_ram_din", ram_din, cpu_wdata);
            ref_mem[cpu_addr] = cpu_wdata;
          end else begin
            cnew = 1; cnd = ref_mem[cpu_addr];
          end
        end
        if (ld_fell) begin
          checkOutput("ld_ram_op", {ram_we, ram_addr, ram_din}, {1'b1, m_ld_addr, m_ld_data});
          ref_mem[m_ld_addr] = m_ld_data;
          m_busy = 0;
        end
        checkOutput("ld_busy", ld_busy, m_busy);
        checkOutput("ld_overrun", ld_overrun, m_ovr);
        checkOutput("vid_rvalid", vid_rvalid, vp1);
        if (vp1) last_v = vd1;
        checkOutput("vid_rdata", vid_rdata, last_v);
        checkOutput("cpu_rvalid", cpu_rvalid, cp1);
        if (cp1) last_c = cd1;
        checkOutput("cpu_rdata", cpu_rdata, last_c);
        vp1 = vp0; vd1 = vd0; vp0 = vnew; vd0 = vnd;
        cp1 = cp0; cd1 = cd0; cp0 = cnew; cd0 = cnd;
        cpu_wait = (cpu_req && !cpu_ack) ? cpu_wait + 1 : 0;
      end
      if (reset && ld_wr) begin
        if (m_busy) begin
          m_ovr = 1;
        end else begin
          m_busy = 1; m_ld_addr = ld_addr; m_ld_data = ld_data;
        end
      end
      rst_last = reset;
    end
  end

  task automatic applyStimulus(input logic vr, input logic [15:0] va,
                               input logic cr, input logic cwe, input logic [15:0] ca,
                               input logic [7:0] cwd,
                               input logic lw, input logic [15:0] la, input logic [7:0] ldd);
    @(posedge clk);
    #1;
    vid_req = vr; vid_addr = va;
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    ld_wr = lw; ld_addr = la; ld_data = ldd;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0);
  endtask

  // One solo access; offsets are counted in cycles from the request cycle.
  task automatic access(input bit is_vid, input logic we, input logic [15:0] a,
                        input logic [7:0] d, output logic [7:0] rd,
                        output int ack_off, output int rv_off);
    int t;
    bit got;
    rd = '0; ack_off = -1; rv_off = -1;
    if (is_vid) applyStimulus(1'b1, a, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0);
    else        applyStimulus(1'b0, 16'h0, 1'b1, we, a, d, 1'b0, 16'h0, 8'h0);
    t = 0; got = 0;
    while (!got && t < 40) begin
      @(negedge clk);
      if ((is_vid && vid_ack) || (!is_vid && cpu_ack)) begin
        got = 1; ack_off = t;
      end
      t++;
    end
    checkOutput("ack_seen", got, 1);
    idleInputs();
    if (is_vid || !we) begin
      got = 0;
      while (!got && t < 40) begin
        @(negedge clk);
        if ((is_vid && vid_rvalid) || (!is_vid && cpu_rvalid)) begin
          got = 1; rv_off = t;
          rd = is_vid ? vid_rdata : cpu_rdata;
        end
        t++;
      end
      checkOutput("rvalid_seen", got, 1);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [7:0] rd;
    int ack_off, rv_off, en_cnt, n;
    logic [9:0] order;
    bit bv, bc;

    reset = 1'b0;
    vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_wr = 0; ld_addr = '0; ld_data = '0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] idle window");
    en_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (ram_en) en_cnt++;
    end
    checkOutput("idle_ram_en_cycles", en_cnt, 0);

    $display("[TB] solo CPU read");
    access(1'b0, 1'b0, 16'h1234, 8'h00, rd, ack_off, rv_off);
    checkOutput("solo_cpu_ack_latency", ack_off, 1);
    checkOutput("solo_cpu_rvalid_latency", rv_off, 3);
    checkOutput("solo_cpu_rdata", rd, 8'h5A);

    $display("[TB] continuous video and CPU");
    vid_addr = 16'h3000; cpu_addr = 16'h4000; cpu_we = 1'b0;
    applyStimulus(1'b1, 16'h3000, 1'b1, 1'b0, 16'h4000, 8'h00, 1'b0, 16'h0, 8'h0);
    n = 0; order = '0;
    for (int c = 0; c < 300 && n < 10; c++) begin
      @(negedge clk);
      bv = vid_ack; bc = cpu_ack;
      if (bv || bc) begin
        if (n < 10) order[n] = bc;
        n++;
      end
      @(posedge clk);
      #1;
      if (bv) vid_addr = vid_addr + 16'h0101;
      if (bc) cpu_addr = cpu_addr + 16'h0011;
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    checkOutput("grant_count", n, 10);
    checkOutput("grant_order", order, 10'h210);
    repeat (5) @(posedge clk);

    $display("[TB] loader overrun");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0100, 8'hA5);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0100, 8'hFF);
    idleInputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("ld_overrun_sticky", ld_overrun, 1);
    access(1'b0, 1'b0, 16'h0100, 8'h00, rd, ack_off, rv_off);
    checkOutput("ld_written_data", rd, 8'hA5);

    $display("[TB] CPU write then video read");
    access(1'b0, 1'b1, 16'h2000, 8'h3C, rd, ack_off, rv_off);
    checkOutput("cpu_write_ack_latency", ack_off, 1);
    access(1'b1, 1'b0, 16'h2000, 8'h00, rd, ack_off, rv_off);
    checkOutput("vid_ack_latency", ack_off, 1);
    checkOutput("vid_rvalid_latency", rv_off, 3);
    checkOutput("vid_reads_cpu_write", rd, 8'h3C);

    $display("[TB] reset during DATA");
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0100, 8'h00, 1'b1, 16'h0500, 8'h77);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    checkOutput("pre_reset_cpu_ack", cpu_ack, 1);
    checkOutput("pre_reset_ld_busy", ld_busy, 1);
    idleInputs();
    reset = 1'b0;
    idleInputs();
    @(negedge clk);
    checkOutput("reset_no_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("reset_ld_busy", ld_busy, 0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 0);
    idleInputs();
    reset = 1'b1;
    access(1'b0, 1'b0, 16'h1234, 8'h00, rd, ack_off, rv_off);
    checkOutput("post_reset_ack_latency", ack_off, 1);
    checkOutput("post_reset_rvalid_latency", rv_off, 3);
    checkOutput("post_reset_rdata", rd, 8'h5A);
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
